// File: rtl/twofish_subkey_sched.sv
// Twofish 128-bit key schedule: one subkey pair per cycle into a 40 x 32-bit table.
// Optional KS_ZEROIZE_EN builds the clr zeroize path. key[127:120] is key byte m0.
module twofish_subkey_sched #(
    parameter int NPAIR = 20,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [127:0]  key,
    output logic          busy,
    output logic          keys_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          clr
);
    localparam int DEPTH = 2 * NPAIR;

    // nibble n of each q-table lives at bits [4n+3:4n]
    localparam logic [63:0] Q0T0 = 64'h4ACE95B023F6D718;
    localparam logic [63:0] Q0T1 = 64'hD9076A4F53218BCE;
    localparam logic [63:0] Q0T2 = 64'h17423F8C09D6E5AB;
    localparam logic [63:0] Q0T3 = 64'hAC5803B9E6214F7D;
    localparam logic [63:0] Q1T0 = 64'h5CA04913E67FDB82;
    localparam logic [63:0] Q1T1 = 64'h809F5AD673C4B2E1;
    localparam logic [63:0] Q1T2 = 64'hF3B28DE0A96157C4;
    localparam logic [63:0] Q1T3 = 64'hA802F746ED3C159B;

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

    function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] n);
        return t[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] qperm(input logic s, input logic [7:0] x);
        logic [3:0] a, b, c, d;
        a = x[7:4];
        b = x[3:0];
        c = a ^ b;
        d = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a = nib(s ? Q1T0 : Q0T0, c);
        b = nib(s ? Q1T1 : Q0T1, d);
        c = a ^ b;
        d = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
        a = nib(s ? Q1T2 : Q0T2, c);
        b = nib(s ? Q1T3 : Q0T3, d);
        return {b, a};
    endfunction

    // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h69 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] hfn(input logic [7:0] x,
                                        input logic [31:0] l0,
                                        input logic [31:0] l1);
        logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
        y0 = qperm(1'b1, qperm(1'b0, qperm(1'b0, x) ^ l1[7:0])   ^ l0[7:0]);
        y1 = qperm(1'b0, qperm(1'b0, qperm(1'b1, x) ^ l1[15:8])  ^ l0[15:8]);
        y2 = qperm(1'b1, qperm(1'b1, qperm(1'b0, x) ^ l1[23:16]) ^ l0[23:16]);
        y3 = qperm(1'b0, qperm(1'b1, qperm(1'b1, x) ^ l1[31:24]) ^ l0[31:24]);
        z0 = y0 ^ gmul(y1, 8'hEF) ^ gmul(y2, 8'h5B) ^ gmul(y3, 8'h5B);
        z1 = gmul(y0, 8'h5B) ^ gmul(y1, 8'hEF) ^ gmul(y2, 8'hEF) ^ y3;
        z2 = gmul(y0, 8'hEF) ^ gmul(y1, 8'h5B) ^ y2 ^ gmul(y3, 8'hEF);
        z3 = gmul(y0, 8'hEF) ^ y1 ^ gmul(y2, 8'hEF) ^ gmul(y3, 8'h5B);
        return {z3, z2, z1, z0};
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t      r_state;
    logic [4:0]  r_idx;
    logic        r_busy;
    logic        r_valid;
    logic [127:0] r_key;
    logic [31:0] r_rd_data;
    logic [31:0] r_tab [DEPTH];

    logic [31:0] w_m0, w_m1, w_m2, w_m3;
    logic [31:0] w_a, w_hb, w_b, w_s, w_k0, w_k1;

    assign w_m0 = bswap(r_key[127:96]);
    assign w_m1 = bswap(r_key[95:64]);
    assign w_m2 = bswap(r_key[63:32]);
    assign w_m3 = bswap(r_key[31:0]);

    assign w_a  = hfn({2'b00, r_idx, 1'b0}, w_m0, w_m2);
    assign w_hb = hfn({2'b00, r_idx, 1'b1}, w_m1, w_m3);
    assign w_b  = {w_hb[23:0], w_hb[31:24]};
    assign w_k0 = w_a + w_b;
    assign w_s  = w_a + {w_b[30:0], 1'b0};
    assign w_k1 = {w_s[22:0], w_s[31:23]};

`ifndef KS_ZEROIZE_EN
    logic w_unused_clr;
    assign w_unused_clr = clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_key     <= '0;
            r_rd_data <= '0;
            for (int j = 0; j < DEPTH; j++) r_tab[j] <= '0;
        end else begin
            r_rd_data <= (rd_addr < AW'(DEPTH)) ? r_tab[rd_addr] : '0;
`ifdef KS_ZEROIZE_EN
            if (clr) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_key   <= '0;
                for (int j = 0; j < DEPTH; j++) r_tab[j] <= '0;
            end else
`endif
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_key   <= key;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_tab[{r_idx, 1'b0}] <= w_k0;
                    r_tab[{r_idx, 1'b1}] <= w_k1;
                    if (r_idx == 5'(NPAIR - 1)) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign keys_valid = r_valid;
    assign rd_data    = r_rd_data;

endmodule
